// File: rtl/bcd_seq_converter_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// FSM state encodings and elaboration-time sizing helpers.
package bcd_seq_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // True when 'digits' decimal digits can hold every value of a 'width'-bit input.
  function automatic bit digitsFit(input int width, input int digits);
    longint unsigned pow10;
    longint unsigned maxVal;
    pow10 = 64'd1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'd10;
    end
    maxVal = (64'd1 << width) - 64'd1;
    return (pow10 > maxVal);
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pure combinational correction; the 4-bit result never needs a carry out.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes and optional leading-zero blank flags.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_blank,
  output logic                  busy
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 4) begin : g_bad_width
    $error("bcd_seq_converter: WIDTH must be at least 4");
  end
  if (!digitsFit(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small to hold 2**WIDTH-1");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0]       binSr_q;
  logic [BCD_W-1:0]       bcdSr_q;
  logic [CNT_W-1:0]       count_q;
  logic [BCD_W-1:0]       outBcd_q;
  logic [DIGITS-1:0]      outBlank_q;

  logic                   accept;
  logic                   lastShift;
  logic [BCD_W-1:0]       bcdAdj;
  logic [BCD_W+WIDTH-1:0] shiftAll;
  logic [BCD_W-1:0]       bcdNext;
  logic [WIDTH-1:0]       binNext;
  logic [DIGITS-1:0]      blankNext;
  logic                   allZero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (bcdSr_q[4*g +: 4]),
      .digit_o (bcdAdj[4*g +: 4])
    );
  end

  assign lastShift = (state_q == SHIFT) && (count_q == LAST_COUNT);

  // State register; reset forces the converter back to an idle, empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE can chain straight into SHIFT when a new input is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (lastShift) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT);
  end

  // One double-dabble step: correct every digit, then shift the combined register left.
  always_comb begin
    shiftAll = {bcdAdj, binSr_q} << 1;
    bcdNext  = shiftAll[BCD_W+WIDTH-1:WIDTH];
    binNext  = shiftAll[WIDTH-1:0];
  end

  // Leading-zero flags for the result about to be loaded; digit 0 always shows.
  always_comb begin
    blankNext = '0;
    allZero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allZero      = allZero && (bcdNext[4*i +: 4] == 4'd0);
      blankNext[i] = (BLANK_LZ != 0) && allZero;
    end
  end

  // Shift registers and bit counter: loaded on accept, stepped once per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binSr_q <= '0;
      bcdSr_q <= '0;
      count_q <= '0;
    end else if (accept) begin
      binSr_q <= in_bin;
      bcdSr_q <= '0;
      count_q <= '0;
    end else if (state_q == SHIFT) begin
      binSr_q <= binNext;
      bcdSr_q <= bcdNext;
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Result registers: captured on the final shift and held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outBcd_q   <= '0;
      outBlank_q <= '0;
    end else if (lastShift) begin
      outBcd_q   <= bcdNext;
      outBlank_q <= blankNext;
    end
  end

  assign out_bcd   = outBcd_q;
  assign out_blank = outBlank_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter: an 8-bit/3-digit
// instance and a 16-bit/5-digit instance share one clock and reset.
module tb_bcd_seq_converter;

  logic clk;
  logic rstN;

  logic        inValid8;
  logic        inReady8;
  logic [7:0]  inBin8;
  logic        outValid8;
  logic        outReady8;
  logic [11:0] outBcd8;
  logic [2:0]  outBlank8;
  logic        busy8;

  logic        inValid16;
  logic        inReady16;
  logic [15:0] inBin16;
  logic        outValid16;
  logic        outReady16;
  logic [19:0] outBcd16;
  logic [4:0]  outBlank16;
  logic        busy16;

  int checks;
  int errors;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut8 (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid8),
    .in_ready  (inReady8),
    .in_bin    (inBin8),
    .out_valid (outValid8),
    .out_ready (outReady8),
    .out_bcd   (outBcd8),
    .out_blank (outBlank8),
    .busy      (busy8)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut16 (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid16),
    .in_ready  (inReady16),
    .in_bin    (inBin16),
    .out_valid (outValid16),
    .out_ready (outReady16),
    .out_bcd   (outBcd16),
    .out_blank (outBlank16),
    .busy      (busy16)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one value to the 8-bit instance for a single accept cycle.
  task automatic applyStimulus(input logic [7:0] value);
    inValid8 = 1'b1;
    inBin8   = value;
    stepClk();
    inValid8 = 1'b0;
    inBin8   = 8'hA5;
    checkOutput("busy after accept", 32'(busy8), 32'd1);
    checkOutput("in_ready in shift", 32'(inReady8), 32'd0);
  endtask

  // Result must appear exactly 8 clocks after the accept edge.
  task automatic waitResult8(input string tag, input logic [11:0] expBcd, input logic [2:0] expBlank);
    repeat (7) stepClk();
    checkOutput({tag, " not early"}, 32'(outValid8), 32'd0);
    stepClk();
    checkOutput({tag, " valid"}, 32'(outValid8), 32'd1);
    checkOutput({tag, " bcd"}, 32'(outBcd8), 32'(expBcd));
    checkOutput({tag, " blank"}, 32'(outBlank8), 32'(expBlank));
  endtask

  task automatic handshake8();
    outReady8 = 1'b1;
    stepClk();
    outReady8 = 1'b0;
    checkOutput("valid drops after handshake", 32'(outValid8), 32'd0);
    checkOutput("in_ready after handshake", 32'(inReady8), 32'd1);
  endtask

  // Full conversion on the 16-bit instance, result expected 16 clocks after accept.
  task automatic run16(input string tag, input logic [15:0] value, input logic [19:0] expBcd, input logic [4:0] expBlank);
    inValid16 = 1'b1;
    inBin16   = value;
    stepClk();
    inValid16 = 1'b0;
    inBin16   = 16'h5A5A;
    repeat (15) stepClk();
    checkOutput({tag, " not early"}, 32'(outValid16), 32'd0);
    stepClk();
    checkOutput({tag, " valid"}, 32'(outValid16), 32'd1);
    checkOutput({tag, " bcd"}, 32'(outBcd16), 32'(expBcd));
    checkOutput({tag, " blank"}, 32'(outBlank16), 32'(expBlank));
    outReady16 = 1'b1;
    stepClk();
    outReady16 = 1'b0;
  endtask

  // Decimal reference built from division, independent of the shift algorithm.
  function automatic logic [19:0] refBcd16(input int value);
    logic [19:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] refBlank16(input int value);
    logic [4:0] b;
    int pow10;
    b = '0;
    pow10 = 10;
    for (int i = 1; i < 5; i++) begin
      b[i] = (value < pow10);
      pow10 = pow10 * 10;
    end
    return b;
  endfunction

  // Directed sequence covering reset, conversions, back-to-back, backpressure and mid-run reset.
  initial begin
    int rv;
    checks     = 0;
    errors     = 0;
    rstN       = 1'b0;
    inValid8   = 1'b0;
    inBin8     = '0;
    outReady8  = 1'b0;
    inValid16  = 1'b0;
    inBin16    = '0;
    outReady16 = 1'b0;

    repeat (2) stepClk();
    checkOutput("reset out_valid", 32'(outValid8), 32'd0);
    checkOutput("reset out_bcd", 32'(outBcd8), 32'd0);
    checkOutput("reset out_blank", 32'(outBlank8), 32'd0);
    checkOutput("reset busy", 32'(busy8), 32'd0);
    checkOutput("reset in_ready", 32'(inReady8), 32'd1);
    rstN = 1'b1;
    stepClk();

    applyStimulus(8'd0);
    waitResult8("zero", 12'h000, 3'b110);
    handshake8();

    applyStimulus(8'd255);
    waitResult8("max", 12'h255, 3'b000);
    handshake8();

    applyStimulus(8'd99);
    waitResult8("ninety-nine", 12'h099, 3'b100);
    handshake8();

    outReady8 = 1'b1;
    inValid8  = 1'b1;
    inBin8    = 8'd7;
    stepClk();
    inBin8 = 8'd128;
    repeat (7) stepClk();
    checkOutput("b2b first not early", 32'(outValid8), 32'd0);
    stepClk();
    checkOutput("b2b first valid", 32'(outValid8), 32'd1);
    checkOutput("b2b first bcd", 32'(outBcd8), 32'h007);
    checkOutput("b2b first blank", 32'(outBlank8), 32'b110);
    checkOutput("b2b in_ready in done", 32'(inReady8), 32'd1);
    stepClk();
    checkOutput("b2b rechained busy", 32'(busy8), 32'd1);
    inBin8 = 8'd200;
    repeat (7) stepClk();
    checkOutput("b2b second not early", 32'(outValid8), 32'd0);
    stepClk();
    checkOutput("b2b second bcd", 32'(outBcd8), 32'h128);
    checkOutput("b2b second valid", 32'(outValid8), 32'd1);
    stepClk();
    inValid8 = 1'b0;
    repeat (8) stepClk();
    checkOutput("b2b third valid", 32'(outValid8), 32'd1);
    checkOutput("b2b third bcd", 32'(outBcd8), 32'h200);
    stepClk();
    outReady8 = 1'b0;
    checkOutput("b2b drained", 32'(outValid8), 32'd0);

    applyStimulus(8'd123);
    inValid8 = 1'b1;
    inBin8   = 8'd250;
    waitResult8("backpressure", 12'h123, 3'b000);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("bp held valid", 32'(outValid8), 32'd1);
      checkOutput("bp held bcd", 32'(outBcd8), 32'h123);
      checkOutput("bp in_ready", 32'(inReady8), 32'd0);
    end
    outReady8 = 1'b1;
    stepClk();
    outReady8 = 1'b0;
    inValid8  = 1'b0;
    inBin8    = 8'd3;
    checkOutput("bp release valid", 32'(outValid8), 32'd0);
    checkOutput("bp release busy", 32'(busy8), 32'd1);
    repeat (8) stepClk();
    checkOutput("bp queued bcd", 32'(outBcd8), 32'h250);
    handshake8();

    applyStimulus(8'd77);
    repeat (4) stepClk();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy8), 32'd0);
    checkOutput("midreset out_valid", 32'(outValid8), 32'd0);
    checkOutput("midreset out_bcd", 32'(outBcd8), 32'd0);
    checkOutput("midreset in_ready", 32'(inReady8), 32'd1);
    stepClk();
    rstN = 1'b1;
    stepClk();
    applyStimulus(8'd42);
    waitResult8("after reset", 12'h042, 3'b100);
    handshake8();

    run16("w16 max", 16'd65535, 20'h65535, 5'b00000);
    run16("w16 thousand", 16'd1000, 20'h01000, 5'b10000);
    run16("w16 zero", 16'd0, 20'h00000, 5'b11110);
    run16("w16 ten-thousand", 16'd10000, 20'h10000, 5'b00000);
    for (int i = 0; i < 20; i++) begin
      rv = int'($urandom_range(65535, 0));
      run16("w16 random", 16'(rv), refBcd16(rv), refBlank16(rv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
